// File: rtl/wb_pkg.sv
// ============================================================================
// Module      : wb_pkg
// Description : Shared types for the writeback stage: result select, load
//               func3 codes and the writeback FSM state.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package wb_pkg;

  typedef enum logic [2:0] {
    RES_ALU = 3'b000,
    RES_MEM = 3'b001,
    RES_PC4 = 3'b010,
    RES_IMM = 3'b011
  } result_src_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } wb_state_t;

endpackage

`default_nettype wire

// File: rtl/load_extend.sv
// ============================================================================
// Module      : load_extend
// Description : Combinational load data alignment and sign/zero extension.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_extend
  import wb_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic [2:0]            i_func3,
  input  logic [2:0]            i_offset,
  input  logic [DATA_WIDTH-1:0] i_raw,
  output logic [DATA_WIDTH-1:0] o_ext
);

  logic [DATA_WIDTH-1:0] w_shifted;

  // Right shift fills with zeros, so misaligned accesses read 0 above bit 63.
  assign w_shifted = i_raw >> {i_offset, 3'b000};

  always_comb begin
    o_ext = '0;
    case (i_func3)
      F3_LB:   o_ext = {{(DATA_WIDTH-8){w_shifted[7]}},   w_shifted[7:0]};
      F3_LH:   o_ext = {{(DATA_WIDTH-16){w_shifted[15]}}, w_shifted[15:0]};
      F3_LW:   o_ext = {{(DATA_WIDTH-32){w_shifted[31]}}, w_shifted[31:0]};
      F3_LD:   o_ext = w_shifted;
      F3_LBU:  o_ext = {{(DATA_WIDTH-8){1'b0}},  w_shifted[7:0]};
      F3_LHU:  o_ext = {{(DATA_WIDTH-16){1'b0}}, w_shifted[15:0]};
      F3_LWU:  o_ext = {{(DATA_WIDTH-32){1'b0}}, w_shifted[31:0]};
      default: o_ext = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/writeback_stage.sv
// ============================================================================
// Module      : writeback_stage
// Description : Final pipeline stage; waits for loads, selects the result and
//               issues one registered register-file write per instruction.
//               Optional retire counter enabled by WB_RETIRE_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module writeback_stage
  import wb_pkg::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  i_clk,
  input  logic                  i_arst,
  input  logic                  i_valid,
  input  logic                  i_flush,
  input  logic [2:0]            i_result_src,
  input  logic                  i_reg_we,
  input  logic [REG_ADDR_W-1:0] i_rd_addr,
  input  logic [2:0]            i_func3,
  input  logic [DATA_WIDTH-1:0] i_alu_result,
  input  logic [ADDR_WIDTH-1:0] i_pc_plus4,
  input  logic [DATA_WIDTH-1:0] i_imm_ext,
  input  logic                  i_mem_ack,
  input  logic [DATA_WIDTH-1:0] i_mem_read_data,
  output logic                  o_stall,
  output logic                  o_reg_we,
  output logic [REG_ADDR_W-1:0] o_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_write_data
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [63:0]           o_retired_cnt
`endif
);

  wb_state_t             r_state;
  logic                  r_cap_we;
  logic [REG_ADDR_W-1:0] r_cap_rd;
  logic [2:0]            r_cap_func3;
  logic [2:0]            r_cap_off;

  logic                  w_is_mem;
  logic                  w_accept;
  logic [DATA_WIDTH-1:0] w_sel;
  logic [DATA_WIDTH-1:0] w_load_ext;

  assign w_is_mem = (i_result_src == 3'(RES_MEM));
  assign w_accept = (r_state == IDLE) && i_valid && !i_flush;
  assign o_stall  = (r_state == WAIT_MEM);

  always_comb begin
    w_sel = i_alu_result;
    case (result_src_t'(i_result_src))
      RES_PC4: w_sel = DATA_WIDTH'(i_pc_plus4);
      RES_IMM: w_sel = i_imm_ext;
      default: w_sel = i_alu_result;
    endcase
  end

  load_extend #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_load_extend (
    .i_func3  (r_cap_func3),
    .i_offset (r_cap_off),
    .i_raw    (i_mem_read_data),
    .o_ext    (w_load_ext)
  );

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      r_state         <= IDLE;
      r_cap_we        <= 1'b0;
      r_cap_rd        <= '0;
      r_cap_func3     <= '0;
      r_cap_off       <= '0;
      o_reg_we        <= 1'b0;
      o_rd_addr       <= '0;
      o_rd_write_data <= '0;
    end else begin
      o_reg_we <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (w_is_mem) begin
              r_state     <= WAIT_MEM;
              r_cap_we    <= i_reg_we;
              r_cap_rd    <= i_rd_addr;
              r_cap_func3 <= i_func3;
              r_cap_off   <= i_alu_result[2:0];
            end else if (i_reg_we && (i_rd_addr != '0)) begin
              o_reg_we        <= 1'b1;
              o_rd_addr       <= i_rd_addr;
              o_rd_write_data <= w_sel;
            end
          end
        end
        WAIT_MEM: begin
          // Flush wins over a same-cycle ack; the load is abandoned.
          if (i_flush) begin
            r_state <= IDLE;
          end else if (i_mem_ack) begin
            r_state <= IDLE;
            if (r_cap_we && (r_cap_rd != '0)) begin
              o_reg_we        <= 1'b1;
              o_rd_addr       <= r_cap_rd;
              o_rd_write_data <= w_load_ext;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef WB_RETIRE_CNT_EN
  logic w_retire;

  assign w_retire = (w_accept && !w_is_mem) ||
                    ((r_state == WAIT_MEM) && !i_flush && i_mem_ack);

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      o_retired_cnt <= '0;
    end else if (w_retire) begin
      o_retired_cnt <= o_retired_cnt + 64'd1;
    end
  end
`endif

endmodule

`default_nettype wire
